// File: rtl/aes_keyram_pkg.sv
// Shared definitions for the multi-context AES round-key RAM:
// key-size encoding, per-mode word counts and FSM state types.
package aes_keyram_pkg;

  typedef enum logic [1:0] {
    MODE_AES128 = 2'b00,
    MODE_AES192 = 2'b01,
    MODE_AES256 = 2'b10,
    MODE_RSVD   = 2'b11
  } key_mode_e;

  localparam logic [4:0] WORDS_AES128 = 5'd22;
  localparam logic [4:0] WORDS_AES192 = 5'd26;
  localparam logic [4:0] WORDS_AES256 = 5'd30;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_LOAD = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } r_state_e;

  // Reserved mode yields zero words; callers never start a transfer with it.
  function automatic logic [4:0] words_for_mode(input logic [1:0] mode);
    logic [4:0] n;
    case (key_mode_e'(mode))
      MODE_AES128: n = WORDS_AES128;
      MODE_AES192: n = WORDS_AES192;
      MODE_AES256: n = WORDS_AES256;
      default:     n = 5'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aes_keyram_dpram.sv
// Simple dual-port RAM: one write port, one read port with registered
// output. The array carries no reset so it maps onto block RAM.
module aes_keyram_dpram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 120,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_keyram_multi.sv
// Multi-context round-key store: independent load and stream engines sharing
// one dual-port RAM, with per-context valid flags and stored key size.
module aes_keyram_multi
  import aes_keyram_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int NUM_CTX   = 4,
  parameter int CTX_DEPTH = 30
) (
  input  logic                       clk,
  input  logic                       kill,
  input  logic                       wr_start,
  input  logic [$clog2(NUM_CTX)-1:0] wr_ctx,
  input  logic [1:0]                 wr_mode,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       wr_done,
  input  logic                       rd_start,
  input  logic [$clog2(NUM_CTX)-1:0] rd_ctx,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  output logic                       rd_busy,
  output logic                       rd_err,
  output logic [NUM_CTX-1:0]         ctx_valid,
  output logic [1:0]                 dbg_state
);

  localparam int CW    = $clog2(NUM_CTX);
  localparam int DEPTH = NUM_CTX * CTX_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  // Handshake: a word moves on every rising edge where wr_valid && wr_ready;
  // wr_ready depends only on state, never on wr_valid.
  w_state_e          wst_q, wst_d;
  logic [CW-1:0]     wctx_q;
  logic [1:0]        wmode_q;
  logic [4:0]        widx_q;
  logic              wr_done_q;
  logic [NUM_CTX-1:0] ctx_valid_q;
  logic [1:0]        ctx_mode_q [NUM_CTX];

  r_state_e          rst_q, rst_d;
  logic [CW-1:0]     rctx_q;
  logic [1:0]        rmode_q;
  logic [4:0]        ridx_q;
  logic              rd_valid_q, rd_last_q, rd_err_q;

  logic              wr_go, wr_fire, wr_final, rd_owns_wctx;
  logic              rd_go, rd_rej, rd_issue, rd_issue_last;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (kill) wst_q <= W_IDLE;
    else      wst_q <= wst_d;
  end

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE:  if (wr_go)    wst_d = W_LOAD;
      W_LOAD:  if (wr_final) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (wst_q == W_LOAD);
    wr_fire  = wr_valid && wr_ready;
    wr_final = wr_fire && (widx_q == (words_for_mode(wmode_q) - 5'd1));
    // A context being streamed, or about to start streaming, cannot be reloaded.
    rd_owns_wctx = (rd_busy && (rctx_q == wr_ctx)) || (rd_go && (rd_ctx == wr_ctx));
    wr_go = wr_start && (wst_q == W_IDLE) && (wr_mode != 2'b11) && !rd_owns_wctx;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wctx_q      <= '0;
      wmode_q     <= 2'b00;
      widx_q      <= 5'd0;
      wr_done_q   <= 1'b0;
      ctx_valid_q <= '0;
      for (int i = 0; i < NUM_CTX; i++) ctx_mode_q[i] <= 2'b00;
    end else begin
      wr_done_q <= wr_final;
      if (wr_go) begin
        wctx_q              <= wr_ctx;
        wmode_q             <= wr_mode;
        widx_q              <= 5'd0;
        ctx_valid_q[wr_ctx] <= 1'b0;
      end else if (wr_fire) begin
        widx_q <= widx_q + 5'd1;
      end
      if (wr_final) begin
        ctx_valid_q[wctx_q] <= 1'b1;
        ctx_mode_q[wctx_q]  <= wmode_q;
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (kill) rst_q <= R_IDLE;
    else      rst_q <= rst_d;
  end

  always_comb begin
    rst_d = rst_q;
    case (rst_q)
      R_IDLE:  if (rd_go)         rst_d = R_RUN;
      R_RUN:   if (rd_issue_last) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  // The RAM adds one cycle, so busy extends through the final data beat.
  always_comb begin
    rd_issue      = (rst_q == R_RUN);
    rd_issue_last = rd_issue && (ridx_q == (words_for_mode(rmode_q) - 5'd1));
    rd_busy       = rd_issue || rd_valid_q;
    rd_go         = rd_start && (rst_q == R_IDLE) && !rd_busy && ctx_valid_q[rd_ctx];
    rd_rej        = rd_start && (rst_q == R_IDLE) && !rd_busy && !ctx_valid_q[rd_ctx];
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      rctx_q     <= '0;
      rmode_q    <= 2'b00;
      ridx_q     <= 5'd0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_err_q   <= rd_rej;
      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue_last;
      if (rd_go) begin
        rctx_q  <= rd_ctx;
        rmode_q <= ctx_mode_q[rd_ctx];
        ridx_q  <= 5'd0;
      end else if (rd_issue) begin
        ridx_q <= ridx_q + 5'd1;
      end
    end
  end

  // ---------------- storage ----------------
  assign wr_addr = AW'(wctx_q) * AW'(CTX_DEPTH) + AW'(widx_q);
  assign rd_addr = AW'(rctx_q) * AW'(CTX_DEPTH) + AW'(ridx_q);

  aes_keyram_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire && !kill),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_issue),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign wr_done   = wr_done_q;
  assign ctx_valid = ctx_valid_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign dbg_state = {wst_q == W_LOAD, rst_q == R_RUN};

endmodule
